// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings, state enum and field widths for the cpu core
package cpu_pkg;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;
  localparam int OPC_W    = 3;
  localparam int OP_W     = 2;
  localparam int SH_W     = 2;
  localparam int IMM_W    = 8;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE
  } state_t;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
  localparam logic [OP_W-1:0] OP_AND     = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

  localparam logic [SH_W-1:0] SH_NONE = 2'b00;
  localparam logic [SH_W-1:0] SH_LSL  = 2'b01;
  localparam logic [SH_W-1:0] SH_LSR  = 2'b10;
  localparam logic [SH_W-1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT} alu_op_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction
endpackage

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - register file, A/B/C registers, shifter, ALU and NVZ status
// Shift code 11 is ASR#1 when CPU_ASR_EN is defined, otherwise LSR#1.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_a,
  input  logic              load_b,
  input  logic              load_c,
  input  logic              write,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] wnum,
  input  logic [SH_W-1:0]   shift,
  input  alu_op_t           alu_op,
  input  logic              asel_zero,
  input  logic              bsel_imm,
  input  logic [IMM_W-1:0]  imm8,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z
);
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic              n_q, n_d, v_q, v_d, z_q, z_d;
  logic [DATA_W-1:0] rdata_a, rdata_b, sh_b, a_in, b_in, alu_res;
  logic              alu_v;

  cpu_regfile REGFILE (
    .clk     (clk),
    .reset   (reset),
    .write   (write),
    .wnum    (wnum),
    .wdata   (c_q),
    .rnum_a  (rn),
    .rnum_b  (rm),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_comb begin
    sh_b = b_q;
    case (shift)
      SH_NONE: sh_b = b_q;
      SH_LSL:  sh_b = {b_q[DATA_W-2:0], 1'b0};
      SH_LSR:  sh_b = {1'b0, b_q[DATA_W-1:1]};
`ifdef CPU_ASR_EN
      SH_ASR:  sh_b = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
`else
      SH_ASR:  sh_b = {1'b0, b_q[DATA_W-1:1]};
`endif
    endcase
  end

  // The immediate bypasses the shifter: its low bits overlap the shift field.
  assign a_in = asel_zero ? '0 : a_q;
  assign b_in = bsel_imm ? sext_imm(imm8) : sh_b;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res = a_in + b_in;
        alu_v   = (a_in[DATA_W-1] == b_in[DATA_W-1]) && (alu_res[DATA_W-1] != a_in[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res = a_in - b_in;
        alu_v   = (a_in[DATA_W-1] != b_in[DATA_W-1]) && (alu_res[DATA_W-1] != a_in[DATA_W-1]);
      end
      ALU_AND: alu_res = a_in & b_in;
      ALU_NOT: alu_res = ~b_in;
    endcase
  end

  always_comb begin
    a_d = load_a ? rdata_a : a_q;
    b_d = load_b ? rdata_b : b_q;
    c_d = load_c ? alu_res : c_q;
    n_d = load_c ? alu_res[DATA_W-1] : n_q;
    v_d = load_c ? alu_v : v_q;
    z_d = load_c ? (alu_res == '0) : z_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      n_q <= n_d;
      v_q <= v_d;
      z_q <= z_d;
    end
  end

  assign out = c_q;
  assign N   = n_q;
  assign V   = v_q;
  assign Z   = z_q;
endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - eight 16-bit registers, one write port, two combinational read ports
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [REG_AW-1:0] wnum,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] rnum_a,
  input  logic [REG_AW-1:0] rnum_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] rview;
  logic [DATA_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

  assign R0 = regs_q[0];
  assign R1 = regs_q[1];
  assign R2 = regs_q[2];
  assign R3 = regs_q[3];
  assign R4 = regs_q[4];
  assign R5 = regs_q[5];
  assign R6 = regs_q[6];
  assign R7 = regs_q[7];

  // Reads see the registered value, so a same-cycle write is not forwarded.
  assign rview   = {R7, R6, R5, R4, R3, R2, R1, R0};
  assign rdata_a = rview[rnum_a];
  assign rdata_b = rview[rnum_b];

  always_comb begin
    regs_d = regs_q;
    if (write) regs_d[wnum] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end
endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - multicycle 16-bit core: instruction register, controller FSM, datapath DP
// Optional ASR#1 for shift code 11 is enabled by defining CPU_ASR_EN.
module cpu
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w
);
  logic [DATA_W-1:0] ir_q, ir_d;
  state_t            state_q, state_d;
  logic              load_a_q, load_a_d, load_b_q, load_b_d;
  logic              load_c_q, load_c_d, write_q, write_d, w_q, w_d;

  logic [OPC_W-1:0]  opc;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rn, rd, rm, wnum;
  logic [SH_W-1:0]   sh;
  logic              is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;
  alu_op_t           alu_op;

  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  assign is_mov_imm = (opc == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opc == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu     = (opc == OPC_ALU);
  assign is_mvn     = is_alu && (op == OP_MVN);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign wnum       = is_mov_imm ? rn : rd;

  always_comb begin
    alu_op = ALU_ADD;
    if (is_alu) begin
      case (op)
        OP_CMP:  alu_op = ALU_SUB;
        OP_AND:  alu_op = ALU_AND;
        OP_MVN:  alu_op = ALU_NOT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign ir_d = load ? in : ir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ir_q <= '0;
    else       ir_q <= ir_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)                state_d = S_EXEC;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu)               state_d = S_GET_A;
        else                           state_d = S_WAIT;
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = is_cmp ? S_WAIT : S_WRITE;
      S_WRITE:  state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
    // Strobes are registered so each is high for exactly the state it acts in.
    load_a_d = (state_d == S_GET_A);
    load_b_d = (state_d == S_GET_B);
    load_c_d = (state_d == S_EXEC);
    write_d  = (state_d == S_WRITE);
    w_d      = (state_d == S_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_WAIT;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      load_c_q <= 1'b0;
      write_q  <= 1'b0;
      w_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
      load_c_q <= load_c_d;
      write_q  <= write_d;
      w_q      <= w_d;
    end
  end

  assign w = w_q;

  cpu_datapath DP (
    .clk       (clk),
    .reset     (reset),
    .load_a    (load_a_q),
    .load_b    (load_b_q),
    .load_c    (load_c_q),
    .write     (write_q),
    .rn        (rn),
    .rm        (rm),
    .wnum      (wnum),
    .shift     (sh),
    .alu_op    (alu_op),
    .asel_zero (!is_alu || is_mvn),
    .bsel_imm  (is_mov_imm),
    .imm8      (ir_q[7:0]),
    .out       (out),
    .N         (N),
    .V         (V),
    .Z         (Z)
  );
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed plus random instruction bench for cpu with an architectural reference model
module tb_cpu;
  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in, out;
  logic        N, V, Z, w;

  cpu dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .load  (load),
    .in    (in),
    .out   (out),
    .N     (N),
    .V     (V),
    .Z     (Z),
    .w     (w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_r [8];
  logic [15:0] m_out;
  logic        m_n, m_v, m_z;
  logic [15:0] dut_r [8];

  assign dut_r[0] = dut.DP.REGFILE.R0;
  assign dut_r[1] = dut.DP.REGFILE.R1;
  assign dut_r[2] = dut.DP.REGFILE.R2;
  assign dut_r[3] = dut.DP.REGFILE.R3;
  assign dut_r[4] = dut.DP.REGFILE.R4;
  assign dut_r[5] = dut.DP.REGFILE.R5;
  assign dut_r[6] = dut.DP.REGFILE.R6;
  assign dut_r[7] = dut.DP.REGFILE.R7;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] shv(input logic [15:0] x, input logic [1:0] c);
    case (c)
      2'd0: return x;
      2'd1: return x * 16'd2;
      2'd2: return x / 16'd2;
`ifdef CPU_ASR_EN
      default: return $signed(x) >>> 1;
`else
      default: return x / 16'd2;
`endif
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_out = 16'h0; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
  endtask

  // lat: exact completion edge count, or 0 meaning "at most 6 edges".
  task automatic model(input logic [15:0] instr, output int lat);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] a, b, res;
    int          sa, sb, r;
    bit          vv, wr;
    logic [2:0]  dst;
    opc = instr[15:13]; op = instr[12:11]; rn = instr[10:8];
    rd  = instr[7:5];   sh = instr[4:3];   rm = instr[2:0];
    vv = 0; wr = 1; dst = rd; res = 16'h0;
    if (opc == 3'b110 && op == 2'b10) begin
      sa = $signed(instr[7:0]);
      res = sa[15:0]; dst = rn; lat = 4;
    end else if (opc == 3'b110 && op == 2'b00) begin
      res = shv(m_r[rm], sh); lat = 0;
    end else if (opc == 3'b101) begin
      a = m_r[rn]; b = shv(m_r[rm], sh); lat = 0;
      sa = $signed(a); sb = $signed(b);
      case (op)
        2'd0: begin r = sa + sb; vv = (r > 32767) || (r < -32768); res = r[15:0]; end
        2'd1: begin r = sa - sb; vv = (r > 32767) || (r < -32768); res = r[15:0]; wr = 0; end
        2'd2: res = a & b;
        default: res = ~b;
      endcase
    end else begin
      lat = 2;
      return;
    end
    m_out = res; m_n = res[15]; m_z = (res == 16'h0); m_v = vv;
    if (wr) m_r[dst] = res;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_out"}, out, m_out);
    chk({tag, "_nvz"}, {13'b0, N, V, Z}, {13'b0, m_n, m_v, m_z});
    for (int i = 0; i < 8; i++) chk($sformatf("%s_R%0d", tag, i), dut_r[i], m_r[i]);
  endtask

  task automatic run(input logic [15:0] instr, input bit hold_s);
    int lat, edges;
    model(instr, lat);
    @(negedge clk); in = instr; load = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b1;
    @(negedge clk); if (!hold_s) s = 1'b0;
    edges = 1;
    chk("w_fall", {15'b0, w}, 16'd0);
    while (w !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
      if (edges == 2) s = 1'b0;
      if (lat == 4 && edges == 3) chk("imm_c_at_3", out, m_out);
    end
    s = 1'b0;
    if (lat != 0) chk($sformatf("latency_%h", instr), 16'(edges), 16'(lat));
    else          chk($sformatf("latency_le6_%h", instr), {15'b0, edges <= 6}, 16'd1);
    check_state($sformatf("i%h", instr));
  endtask

  initial begin
    int edges;
    logic [15:0] instr;
    int r;
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_w", {15'b0, w}, 16'd1);
    check_state("rst");
    reset = 1'b0;

    run(16'hD105, 0); chk("plan_mov5", out, 16'd5);
    run(16'hD203, 1); chk("plan_mov3", dut_r[2], 16'd3);
    run(16'hA162, 0); chk("plan_add8", out, 16'd8);
    run(16'hA3E9, 0); chk("plan_add18", out, 16'd18);
    run(16'hA2D7, 1); chk("plan_add12", dut_r[6], 16'd12);
    run(16'hB8C1, 0); chk("plan_mvn", out, 16'hFFFA);
    run(16'hB1A2, 0); chk("plan_and", out, 16'd1);
    run(16'hC0B5, 0); chk("plan_lsr_z", {15'b0, Z}, 16'd1);
    run(16'hD410, 0);
    run(16'hAC01, 0); chk("plan_cmp11", out, 16'd11);
    run(16'hAE06, 0); chk("plan_cmp_z", {15'b0, Z}, 16'd1);
    run(16'hD2FD, 0); chk("plan_neg3", out, 16'hFFFD);
    run(16'hD0FF, 0);
    run(16'hC010, 0); chk("plan_7fff", out, 16'h7FFF);
    run(16'hD101, 0);
    run(16'hA061, 0); chk("plan_ovf", {13'b0, N, V, Z}, 16'b110);
    run(16'hD080, 0);
    run(16'hC038, 0);
    run(16'h0123, 0);
    run(16'hC9FF, 1);

    for (int k = 0; k < 150; k++) begin
      instr = 16'($urandom);
      r = $urandom_range(0, 7);
      if (r < 3)      instr[15:13] = 3'b110;
      else if (r < 6) instr[15:13] = 3'b101;
      run(instr, 1'($urandom_range(0, 1)));
    end

    run(16'hD105, 0);
    @(negedge clk); in = 16'hA061; load = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b1;
    @(negedge clk); s = 1'b0;
    edges = 1;
    while (edges < 4) begin @(negedge clk); edges++; end
    chk("pre_rst_w", {15'b0, w}, 16'd0);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_w", {15'b0, w}, 16'd1);
    check_state("midrst");
    @(negedge clk); reset = 1'b0;
    run(16'hD3FE, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
